// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: memory / memory-mapped I/O controller behind the LC-3 control FSM.
// Each mio_en/rw access is captured once, and after WAIT_CYCLES of latency it
// is served against the internal RAM or one of the keyboard and display
// registers. Completion is signalled with a single-cycle r pulse.
//
// Ports
//   i_Clk        sole clock, rising edge
//   reset        synchronous, active-high
//   mio_en, rw   access request from the FSM (rw: 0 = read, 1 = write)
//   mar, mdr     access address and write data
//   mem_data     read data to the MDR mux; held until the next read completes
//   r            access complete, one-cycle pulse
//   kb_valid     keyboard character strobe
//   kb_data      keyboard character
//   disp_ready   display can accept a character
//   ddr_valid    display character strobe, coincident with r
//   ddr_data     display character
module mem_io_ctrl #(
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_Clk,
  input  logic        reset,
  input  logic        mio_en,
  input  logic        rw,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  output logic [15:0] mem_data,
  output logic        r,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  input  logic        disp_ready,
  output logic        ddr_valid,
  output logic [7:0]  ddr_data
);

  localparam int          AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [16:0] DEPTH17   = 17'(MEM_DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  localparam logic [15:0] A_KBSR = 16'hFE00;
  localparam logic [15:0] A_KBDR = 16'hFE02;
  localparam logic [15:0] A_DSR  = 16'hFE04;
  localparam logic [15:0] A_DDR  = 16'hFE06;

  typedef enum logic [1:0] {IDLE, BUSY, READY, DONE} state_t;

  state_t      state, state_d;
  logic [3:0]  cnt, cnt_d;
  logic        cap, acc;

  logic [15:0] a_q, d_q;
  logic        rw_q;
  logic        kb_ready;
  logic [7:0]  kbdr;

  logic [15:0] ram [MEM_DEPTH];
  logic [AW-1:0] ram_idx;
  logic        in_ram, ram_we, kb_clr;
  logic [15:0] rd_data;

  // Next-state logic. acc marks the edge on which the access is performed
  // and r is raised.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    cap     = 1'b0;
    acc     = 1'b0;
    case (state)
      IDLE:  if (mio_en) begin
               cap     = 1'b1;
               cnt_d   = WAIT_INIT;
               state_d = BUSY;
             end
      BUSY:  if (cnt == 4'd0) begin
               acc     = 1'b1;
               state_d = READY;
             end else begin
               cnt_d = cnt - 4'd1;
             end
      READY: state_d = DONE;
      // Hold here until the FSM releases mio_en so a held request cannot
      // start a second access.
      DONE:  if (!mio_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // Full 16-bit compare: device registers never alias into RAM, and RAM
  // never wraps.
  assign in_ram  = {1'b0, a_q} < DEPTH17;
  assign ram_idx = a_q[AW-1:0];
  assign ram_we  = acc && rw_q && in_ram && !reset;
  assign kb_clr  = acc && !rw_q && (a_q == A_KBDR);

  always_comb begin
    rd_data = 16'h0000;
    if (in_ram)                rd_data = ram[ram_idx];
    else if (a_q == A_KBSR)    rd_data = {kb_ready, 15'b0};
    else if (a_q == A_KBDR)    rd_data = {8'b0, kbdr};
    else if (a_q == A_DSR)     rd_data = {disp_ready, 15'b0};
    else if (a_q == A_DDR)     rd_data = {8'b0, ddr_data};
  end

  // RAM has no reset; a reset mid-access suppresses the write via ram_we.
  always_ff @(posedge i_Clk) begin
    if (ram_we) ram[ram_idx] <= d_q;
  end

  always_ff @(posedge i_Clk) begin
    if (reset) begin
      a_q       <= 16'h0000;
      d_q       <= 16'h0000;
      rw_q      <= 1'b0;
      r         <= 1'b0;
      mem_data  <= 16'h0000;
      ddr_valid <= 1'b0;
      ddr_data  <= 8'h00;
      kb_ready  <= 1'b0;
      kbdr      <= 8'h00;
    end else begin
      if (cap) begin
        a_q  <= mar;
        d_q  <= mdr;
        rw_q <= rw;
      end
      r         <= acc;
      ddr_valid <= acc && rw_q && (a_q == A_DDR);
      if (acc && rw_q && (a_q == A_DDR)) ddr_data <= d_q[7:0];
      if (acc && !rw_q) mem_data <= rd_data;
      // A new character arriving on the clearing edge wins.
      if (kb_valid) begin
        kbdr     <= kb_data;
        kb_ready <= 1'b1;
      end else if (kb_clr) begin
        kb_ready <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
module tb_mem_io_ctrl;

  logic        i_Clk = 1'b0;
  logic        reset;
  logic        mio_en, rw;
  logic [15:0] mar, mdr;
  logic [15:0] mem_data;
  logic        r;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        disp_ready;
  logic        ddr_valid;
  logic [7:0]  ddr_data;

  int checks   = 0;
  int failures = 0;

  mem_io_ctrl #(.MEM_DEPTH(4096), .WAIT_CYCLES(2)) dut (
    .i_Clk(i_Clk), .reset(reset), .mio_en(mio_en), .rw(rw), .mar(mar),
    .mdr(mdr), .mem_data(mem_data), .r(r), .kb_valid(kb_valid),
    .kb_data(kb_data), .disp_ready(disp_ready), .ddr_valid(ddr_valid),
    .ddr_data(ddr_data)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  // One complete access. Inputs are driven #1 after an edge while the DUT
  // sits in IDLE; the next edge is the capture edge E0. With WAIT_CYCLES=2
  // r must first be seen after the third edge following E0.
  // kbhit strobes a new keyboard character into the edge that raises r.
  // hold keeps mio_en high that many cycles after r.
  task automatic access(input string tag, input logic wr, input logic [15:0] addr,
                        input logic [15:0] data, input bit kbhit, input int hold,
                        output logic [15:0] rd, output logic dv, output logic [7:0] dd);
    int n;
    int extra;
    bit got;
    mio_en = 1'b1; rw = wr; mar = addr; mdr = data;
    tick();
    n = 0; got = 0;
    while (!got && n < 20) begin
      if (kbhit && n == 2) begin
        kb_valid = 1'b1; kb_data = 8'h42;
      end
      tick();
      kb_valid = 1'b0;
      n++;
      if (r) got = 1;
    end
    chk({tag, "_latency"}, n, 3);
    rd = mem_data; dv = ddr_valid; dd = ddr_data;
    extra = 0;
    repeat (hold) begin
      tick();
      if (r) extra++;
    end
    if (hold > 0) chk({tag, "_held_extra_r"}, extra, 0);
    mio_en = 1'b0;
    tick();
    chk({tag, "_r_one_cycle"}, r, 1'b0);
    chk({tag, "_ddr_valid_low"}, ddr_valid, 1'b0);
    tick();
  endtask

  logic [15:0] rd;
  logic        dv;
  logic [7:0]  dd;

  initial begin
    reset = 1'b1; mio_en = 1'b0; rw = 1'b0; mar = 16'h0; mdr = 16'h0;
    kb_valid = 1'b0; kb_data = 8'h0; disp_ready = 1'b0;
    repeat (3) tick();
    chk("rst_r", r, 1'b0);
    chk("rst_mem_data", mem_data, 16'h0000);
    chk("rst_ddr_valid", ddr_valid, 1'b0);
    chk("rst_ddr_data", ddr_data, 8'h00);
    reset = 1'b0;
    tick();

    // RAM write then read back.
    access("wr10", 1'b1, 16'h0010, 16'h1234, 0, 0, rd, dv, dd);
    chk("wr10_mem_data_unchanged", rd, 16'h0000);
    access("rd10", 1'b0, 16'h0010, 16'h0000, 0, 0, rd, dv, dd);
    chk("rd10_data", rd, 16'h1234);
    access("wr20", 1'b1, 16'h0020, 16'hBEEF, 0, 0, rd, dv, dd);
    chk("wr20_mem_data_unchanged", rd, 16'h1234);
    access("rd20", 1'b0, 16'h0020, 16'h0000, 0, 0, rd, dv, dd);
    chk("rd20_data", rd, 16'hBEEF);

    // mio_en held 10 cycles after r: one access only; next access still
    // shows the full latency, so DONE returned to IDLE.
    access("hold", 1'b0, 16'h0010, 16'h0000, 0, 10, rd, dv, dd);
    chk("hold_data", rd, 16'h1234);
    chk("hold_mem_data_after", mem_data, 16'h1234);

    // Keyboard.
    kb_valid = 1'b1; kb_data = 8'h41;
    tick();
    kb_valid = 1'b0;
    access("kbsr1", 1'b0, 16'hFE00, 16'h0, 0, 0, rd, dv, dd);
    chk("kbsr1_data", rd, 16'h8000);
    access("kbdr1", 1'b0, 16'hFE02, 16'h0, 0, 0, rd, dv, dd);
    chk("kbdr1_data", rd, 16'h0041);
    access("kbsr2", 1'b0, 16'hFE00, 16'h0, 0, 0, rd, dv, dd);
    chk("kbsr2_data", rd, 16'h0000);
    // Writes to KBSR are ignored.
    access("kbsr_wr", 1'b1, 16'hFE00, 16'hFFFF, 0, 0, rd, dv, dd);
    access("kbsr3", 1'b0, 16'hFE00, 16'h0, 0, 0, rd, dv, dd);
    chk("kbsr3_data", rd, 16'h0000);
    // New character on the same edge as the KBDR-read clear: set wins.
    kb_valid = 1'b1; kb_data = 8'h41;
    tick();
    kb_valid = 1'b0;
    access("kbdr2", 1'b0, 16'hFE02, 16'h0, 1, 0, rd, dv, dd);
    chk("kbdr2_data_old_char", rd, 16'h0041);
    access("kbsr4", 1'b0, 16'hFE00, 16'h0, 0, 0, rd, dv, dd);
    chk("kbsr4_set_wins", rd, 16'h8000);
    access("kbdr3", 1'b0, 16'hFE02, 16'h0, 0, 0, rd, dv, dd);
    chk("kbdr3_new_char", rd, 16'h0042);

    // Display.
    disp_ready = 1'b1;
    access("dsr1", 1'b0, 16'hFE04, 16'h0, 0, 0, rd, dv, dd);
    chk("dsr1_data", rd, 16'h8000);
    disp_ready = 1'b0;
    access("dsr2", 1'b0, 16'hFE04, 16'h0, 0, 0, rd, dv, dd);
    chk("dsr2_data", rd, 16'h0000);
    access("ddr_wr", 1'b1, 16'hFE06, 16'h0A5A, 0, 0, rd, dv, dd);
    chk("ddr_wr_valid_with_r", dv, 1'b1);
    chk("ddr_wr_data", dd, 8'h5A);
    access("ddr_rd", 1'b0, 16'hFE06, 16'h0, 0, 0, rd, dv, dd);
    chk("ddr_rd_data", rd, 16'h005A);
    chk("ddr_rd_no_strobe", dv, 1'b0);

    // Reset during BUSY of a write aborts it.
    access("wr30", 1'b1, 16'h0030, 16'h7777, 0, 0, rd, dv, dd);
    mio_en = 1'b1; rw = 1'b1; mar = 16'h0030; mdr = 16'h1111;
    tick();  // E0
    tick();  // BUSY
    reset = 1'b1; mio_en = 1'b0;
    tick();
    chk("rst_busy_r", r, 1'b0);
    chk("rst_busy_mem_data", mem_data, 16'h0000);
    chk("rst_busy_ddr_data", ddr_data, 8'h00);
    chk("rst_busy_ddr_valid", ddr_valid, 1'b0);
    reset = 1'b0;
    begin
      int rs = 0;
      repeat (6) begin
        tick();
        if (r) rs++;
      end
      chk("rst_busy_no_r", rs, 0);
    end
    access("rd30", 1'b0, 16'h0030, 16'h0, 0, 0, rd, dv, dd);
    chk("rd30_unchanged", rd, 16'h7777);

    // Unmapped addresses, including just past the RAM top.
    access("rdC000", 1'b0, 16'hC000, 16'h0, 0, 0, rd, dv, dd);
    chk("rdC000_data", rd, 16'h0000);
    access("wr1000", 1'b1, 16'h1000, 16'h5555, 0, 0, rd, dv, dd);
    access("rd0000", 1'b0, 16'h0000, 16'h0, 0, 0, rd, dv, dd);
    chk("rd0000_no_wrap", rd === 16'h5555, 1'b0);
    access("rd1000", 1'b0, 16'h1000, 16'h0, 0, 0, rd, dv, dd);
    chk("rd1000_data", rd, 16'h0000);
    access("rdFFF", 1'b0, 16'h0FFF, 16'h0, 0, 0, rd, dv, dd);
    chk("rdFFF_no_wrap", rd === 16'h5555, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
